imem_loader: RTL and testbench

Boot-time loader that fills the instruction memory through its word-wide write port from a byte stream (UART receiver or debug bridge). It sits between the byte source and the `i_mem` write port (`writeEnable` / `writeAddress` / `writeData`) and holds the core off (`busy`) while loading. It parses a 2-byte length header, assembles big-endian words and writes them at consecutive byte addresses from 0, so the `i_mem` read path returns them unchanged.

---
 rtl/imem_loader_pkg.sv | 16 +
 rtl/imem_loader.sv | 147 ++++++++++++++
 tb/tb_imem_loader.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/imem_loader_pkg.sv
// Shared types and constants for the boot-time instruction memory loader.
package imem_loader_pkg;

   typedef enum logic [2:0] {
      S_IDLE,
      S_LEN_HI,
      S_LEN_LO,
      S_DATA,
      S_WRITE,
      S_DONE
   } loader_state_t;

   localparam int HDR_BYTES  = 2;
   localparam int WORD_BYTES = 4;

endpackage

// File: rtl/imem_loader.sv
// Byte-stream to i_mem loader: 16-bit word-count header, then big-endian
// words written at consecutive byte addresses from 0.
module imem_loader
   import imem_loader_pkg::*;
#(
   parameter int DATA_WIDTH     = 32,
   parameter int ADDR_WIDTH     = 12,
   parameter int MEM_BYTES      = 4096,
   parameter int TIMEOUT_CYCLES = 1000000
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  start,
   input  logic                  byte_valid,
   input  logic [7:0]            byte_data,
   output logic                  byte_ready,
   output logic                  writeEnable,
   output logic [ADDR_WIDTH-1:0] writeAddress,
   output logic [DATA_WIDTH-1:0] writeData,
   output logic                  busy,
   output logic                  done,
   output logic                  error
);

   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [31:0] MAX_WORDS = 32'(MEM_BYTES / WORD_BYTES);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [ADDR_WIDTH-1:0] ADDR_STEP = ADDR_WIDTH'(WORD_BYTES);

   loader_state_t         state_q, state_d;
   logic [1:0]            idx_q, idx_d;
   logic [DATA_WIDTH-1:0] word_q, word_d;
   logic [ADDR_WIDTH-1:0] addr_q, addr_d;
   logic [15:0]           rem_q, rem_d;
   logic [TW-1:0]         tmo_q, tmo_d;
   logic                  err_q, err_d;

   logic        accept;
   logic [15:0] n_hdr;

   // Handshake decoded purely from state so byte_valid never reaches byte_ready.
   assign byte_ready   = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                         (state_q == S_DATA);
   assign busy         = byte_ready || (state_q == S_WRITE);
   assign writeEnable  = (state_q == S_WRITE);
   assign done         = (state_q == S_DONE);
   assign error        = err_q;
   assign writeAddress = addr_q;
   assign writeData    = word_q;

   assign accept = byte_valid && byte_ready;
   assign n_hdr  = {rem_q[7:0], byte_data};

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      word_d  = word_q;
      addr_d  = addr_q;
      rem_d   = rem_q;
      tmo_d   = tmo_q;
      err_d   = err_q;

      if (byte_ready) begin
         if (accept) begin
            tmo_d = '0;
         end else if (tmo_q == TMO_LAST) begin
            state_d = S_IDLE;
            err_d   = 1'b1;
         end else begin
            tmo_d = tmo_q + 1'b1;
         end
      end

      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               state_d = S_LEN_HI;
               err_d   = 1'b0;
               addr_d  = '0;
               idx_d   = '0;
               tmo_d   = '0;
               rem_d   = '0;
            end
         end
         S_LEN_HI: begin
            if (accept) begin
               rem_d   = n_hdr;
               state_d = S_LEN_LO;
            end
         end
         S_LEN_LO: begin
            if (accept) begin
               rem_d = n_hdr;
               if (n_hdr == 16'd0) begin
                  state_d = S_DONE;
               end else if ({16'd0, n_hdr} > MAX_WORDS) begin
                  state_d = S_IDLE;
                  err_d   = 1'b1;
               end else begin
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (accept) begin
               word_d = {word_q[DATA_WIDTH-9:0], byte_data};
               idx_d  = idx_q + 2'd1;
               if (idx_q == 2'd3) begin
                  state_d = S_WRITE;
               end
            end
         end
         S_WRITE: begin
            addr_d  = addr_q + ADDR_STEP;
            rem_d   = rem_q - 16'd1;
            state_d = (rem_q == 16'd1) ? S_DONE : S_DATA;
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clock) begin
      if (reset) begin
         state_q <= S_IDLE;
         idx_q   <= '0;
         word_q  <= '0;
         addr_q  <= '0;
         rem_q   <= '0;
         tmo_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         word_q  <= word_d;
         addr_q  <= addr_d;
         rem_q   <= rem_d;
         tmo_q   <= tmo_d;
         err_q   <= err_d;
      end
   end

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: header parsing, word assembly, error
// paths, timeout and mid-session reset.
module tb_imem_loader;

   logic        clock;
   logic        reset;
   logic        start;
   logic        byte_valid;
   logic [7:0]  byte_data;
   logic        byte_ready;
   logic        writeEnable;
   logic [11:0] writeAddress;
   logic [31:0] writeData;
   logic        busy;
   logic        done;
   logic        error;

   int n_vec;
   int n_err;

   logic [31:0] wa_q[$];
   logic [31:0] wd_q[$];
   logic [31:0] imem [0:1023];
   int          done_cnt;
   int          we_long;
   logic        prev_we;

   imem_loader #(
      .DATA_WIDTH    (32),
      .ADDR_WIDTH    (12),
      .MEM_BYTES     (4096),
      .TIMEOUT_CYCLES(16)
   ) dut (
      .clock       (clock),
      .reset       (reset),
      .start       (start),
      .byte_valid  (byte_valid),
      .byte_data   (byte_data),
      .byte_ready  (byte_ready),
      .writeEnable (writeEnable),
      .writeAddress(writeAddress),
      .writeData   (writeData),
      .busy        (busy),
      .done        (done),
      .error       (error)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // i_mem model and write/done observers, sampled mid-cycle
   always @(negedge clock) begin
      if (writeEnable) begin
         wa_q.push_back({20'd0, writeAddress});
         wd_q.push_back(writeData);
         imem[writeAddress[11:2]] = writeData;
         if (prev_we) we_long++;
      end
      if (done) done_cnt++;
      prev_we = writeEnable;
   end

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic clear_obs();
      wa_q.delete();
      wd_q.delete();
      done_cnt = 0;
      we_long  = 0;
   endtask

   task automatic do_start();
      start = 1'b1;
      @(posedge clock);
      #1;
      start = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b, input int gap);
      bit acc;
      acc = 1'b0;
      byte_valid = 1'b0;
      repeat (gap) begin
         @(posedge clock);
         #1;
      end
      byte_valid = 1'b1;
      byte_data  = b;
      for (int k = 0; k < 64 && !acc; k++) begin
         @(negedge clock);
         acc = byte_ready;
         @(posedge clock);
         #1;
      end
      byte_valid = 1'b0;
      if (!acc) check("accept_timeout", 32'd0, 32'd1);
   endtask

   logic [7:0] strm [0:9];
   int         gaps [0:9];

   initial begin
      n_vec = 0;
      n_err = 0;
      prev_we = 1'b0;
      done_cnt = 0;
      we_long = 0;
      for (int i = 0; i < 1024; i++) imem[i] = 32'h0;
      strm = '{8'h00, 8'h02, 8'h00, 8'h50, 8'h00, 8'h93,
               8'hDE, 8'hAD, 8'hBE, 8'hEF};
      gaps = '{1, 0, 2, 3, 0, 1, 2, 0, 3, 1};
      reset = 1'b1;
      start = 1'b0;
      byte_valid = 1'b0;
      byte_data = 8'h00;
      repeat (3) @(posedge clock);
      #1;
      check("rst_ready", byte_ready, 0);
      check("rst_we", writeEnable, 0);
      check("rst_addr", writeAddress, 0);
      check("rst_data", writeData, 0);
      check("rst_busy", busy, 0);
      check("rst_done", done, 0);
      check("rst_err", error, 0);
      reset = 1'b0;
      @(posedge clock);
      #1;

      // two words, byte_valid held high
      clear_obs();
      do_start();
      check("t1_busy", busy, 1);
      check("t1_ready", byte_ready, 1);
      for (int i = 0; i < 6; i++) send_byte(strm[i], 0);
      check("t1_we0", writeEnable, 1);
      check("t1_addr0", writeAddress, 32'h0);
      check("t1_data0", writeData, 32'h00500093);
      check("t1_rdy_wr", byte_ready, 0);
      for (int i = 6; i < 10; i++) send_byte(strm[i], 0);
      check("t1_we1", writeEnable, 1);
      check("t1_addr1", writeAddress, 32'h4);
      @(posedge clock);
      #1;
      check("t1_done", done, 1);
      check("t1_busy_d", busy, 0);
      check("t1_we_off", writeEnable, 0);
      @(posedge clock);
      #1;
      check("t1_done_off", done, 0);
      check("t1_nwr", wa_q.size(), 2);
      check("t1_ndone", done_cnt, 1);
      check("t1_mem0", imem[0], 32'h00500093);
      check("t1_mem1", imem[1], 32'hDEADBEEF);

      // same stream with gaps
      clear_obs();
      imem[0] = 32'h0;
      imem[1] = 32'h0;
      do_start();
      for (int i = 0; i < 10; i++) send_byte(strm[i], gaps[i]);
      repeat (3) @(posedge clock);
      #1;
      check("t2_nwr", wa_q.size(), 2);
      if (wa_q.size() == 2) begin
         check("t2_a0", wa_q[0], 32'h0);
         check("t2_d0", wd_q[0], 32'h00500093);
         check("t2_a1", wa_q[1], 32'h4);
         check("t2_d1", wd_q[1], 32'hDEADBEEF);
      end
      check("t2_mem0", imem[0], 32'h00500093);
      check("t2_mem1", imem[1], 32'hDEADBEEF);
      check("t2_we_width", we_long, 0);
      check("t2_ndone", done_cnt, 1);

      // oversize header: 1025 words
      clear_obs();
      do_start();
      send_byte(8'h04, 0);
      send_byte(8'h01, 0);
      check("t3_err", error, 1);
      check("t3_busy", busy, 0);
      check("t3_ready", byte_ready, 0);
      byte_valid = 1'b1;
      repeat (4) @(posedge clock);
      #1;
      byte_valid = 1'b0;
      check("t3_ready2", byte_ready, 0);
      check("t3_err2", error, 1);
      check("t3_nwr", wa_q.size(), 0);
      check("t3_ndone", done_cnt, 0);

      // zero-length header
      clear_obs();
      do_start();
      check("t4_err_clr", error, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      check("t4_done", done, 1);
      check("t4_busy", busy, 0);
      @(posedge clock);
      #1;
      check("t4_done_off", done, 0);
      check("t4_nwr", wa_q.size(), 0);
      check("t4_ndone", done_cnt, 1);

      // stall after two data bytes
      clear_obs();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'hAA, 0);
      send_byte(8'hBB, 0);
      repeat (15) @(posedge clock);
      #1;
      check("t5_busy_pre", busy, 1);
      check("t5_err_pre", error, 0);
      @(posedge clock);
      #1;
      check("t5_err", error, 1);
      check("t5_busy", busy, 0);
      check("t5_nwr", wa_q.size(), 0);
      do_start();
      check("t5_err_clr", error, 0);
      send_byte(8'h00, 0);
      send_byte(8'h00, 0);
      @(posedge clock);
      #1;

      // reset mid-DATA, then a fresh session
      clear_obs();
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h02, 0);
      send_byte(8'h12, 0);
      send_byte(8'h34, 0);
      reset = 1'b1;
      @(posedge clock);
      #1;
      reset = 1'b0;
      check("t6_busy", busy, 0);
      check("t6_ready", byte_ready, 0);
      check("t6_we", writeEnable, 0);
      check("t6_addr", writeAddress, 0);
      check("t6_data", writeData, 0);
      check("t6_done", done, 0);
      check("t6_err", error, 0);
      do_start();
      send_byte(8'h00, 0);
      send_byte(8'h01, 0);
      send_byte(8'h11, 0);
      send_byte(8'h22, 1);
      send_byte(8'h33, 0);
      send_byte(8'h44, 2);
      check("t6_we_new", writeEnable, 1);
      check("t6_addr_new", writeAddress, 32'h0);
      check("t6_data_new", writeData, 32'h11223344);
      repeat (3) @(posedge clock);
      #1;
      check("t6_nwr", wa_q.size(), 1);
      check("t6_ndone", done_cnt, 1);
      check("t6_mem0", imem[0], 32'h11223344);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
